conv_postproc: RTL and testbench
================================

CONV_POSTPROC -- requirements
Module: conv_postproc

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter BORDER, default 2, number of leading columns and rows whose 3x3 window is invalid.
REQ-004 SHALL have port iCLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port iRST  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port iDATA  input  12  convolved pixel, unsigned, raster order.
REQ-007 SHALL have port iDVAL  input  1  iDATA valid this cycle.
REQ-008 SHALL have port iCLR  input  1  synchronous frame restart; clears position and statistics.
REQ-009 SHALL have port iBIN_EN  input  1  binarize output when high.
REQ-010 SHALL have port iTHRESH  input  12  edge threshold, unsigned.
REQ-011 SHALL have port oDATA  output  12  masked, optionally binarized pixel.
REQ-012 SHALL have port oDVAL  output  1  oDATA valid.
REQ-013 SHALL have port oX  output  10  column of the current output pixel.
REQ-014 SHALL have port oY  output  9  row of the current output pixel.
REQ-015 SHALL have port oSOF  output  1  high with oDVAL for pixel (0,0).
REQ-016 SHALL have port oEOF  output  1  high with oDVAL for pixel (IMG_W-1, IMG_H-1).
REQ-017 SHALL have port oEDGE_CNT  output  19  edge-pixel count of the last completed frame.
REQ-018 SHALL have port oCNT_VLD  output  1  one-cycle pulse when oEDGE_CNT updates.

Function
REQ-019 SHALL keep internal column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1); each iDVAL=1 pixel is tagged with the current (x,y).
REQ-020 SHALL advance counters only on iDVAL=1 cycles: x+1; at x=IMG_W-1, x->0 and y+1; at (IMG_W-1, IMG_H-1), x->0 and y->0.
REQ-021 SHALL treat a pixel as masked when x<BORDER or y<BORDER; masked pixels produce value 0 before binarization.
REQ-022 SHALL compute the unmasked value as iDATA when iBIN_EN=0, or (iDATA>=iTHRESH ? 4095 : 0) when iBIN_EN=1.
REQ-023 SHALL classify a pixel as an edge when it is unmasked and iDATA>=iTHRESH, independent of iBIN_EN.
REQ-024 SHALL register all outputs, giving a fixed latency of 1 cycle from an iDVAL=1 input to oDVAL=1 with the corresponding oDATA, oX, oY, oSOF and oEOF.
REQ-025 SHALL hold oDATA, oX and oY unchanged, and drive oDVAL, oSOF and oEOF to 0, in cycles following iDVAL=0.
REQ-026 SHALL count edge pixels in a 19-bit accumulator across the frame.
REQ-027 SHALL, on the last pixel of a frame, load oEDGE_CNT with the accumulator plus that pixel's edge bit, pulse oCNT_VLD in the same cycle as oEOF, and clear the accumulator to 0.
REQ-028 SHALL, when iCLR=1, on the next edge set x, y and the accumulator to 0, drive oDVAL, oSOF, oEOF and oCNT_VLD to 0, discard any concurrent iDVAL pixel, and leave oEDGE_CNT unchanged.
REQ-029 SHALL sample iBIN_EN and iTHRESH per pixel, so a change takes effect on the next valid pixel.
REQ-030 SHALL not stall, backpressure or buffer: every accepted pixel appears exactly once at the output.

Reset
REQ-031 SHALL, while iRST=0, asynchronously force x=0, y=0, accumulator=0, oDATA=0, oDVAL=0, oX=0, oY=0, oSOF=0, oEOF=0, oEDGE_CNT=0 and oCNT_VLD=0.
REQ-032 SHALL, after reset is released mid-frame, treat the next iDVAL pixel as (0,0).

Verification
REQ-033 SHALL pass: after reset, stream a constant 1000 frame with iBIN_EN=0 and iTHRESH=500 -> oDATA=0 for rows 0-1 and columns 0-1, 1000 elsewhere; oEDGE_CNT=638*478=304964 with a single oCNT_VLD pulse coincident with oEOF.
REQ-034 SHALL pass: the same frame with iBIN_EN=1 and iTHRESH=1001 -> all oDATA=0, oEDGE_CNT=0; with iTHRESH=1000 -> interior oDATA=4095.
REQ-035 SHALL pass: iDVAL toggling 1,0,1,0 -> oDVAL follows one cycle later, oX increments only on valid outputs, and oX wraps from 639 to 0 with oY+1.
REQ-036 SHALL pass: iCLR asserted with iDVAL=1 at pixel (300,200) -> no oDVAL that cycle, next pixel tagged (0,0) with oSOF=1, oEDGE_CNT unchanged.
REQ-037 SHALL pass: iRST pulsed low mid-frame -> all outputs 0 immediately; next pixel tagged (0,0) with oSOF=1.
REQ-038 SHALL pass: two back-to-back frames of differing content -> oEDGE_CNT reflects each frame independently, with no carry-over.

Source files
------------

// File: rtl/conv_postproc.sv
// Convolution post-processor: border masking, optional binarization and a per-frame
// edge-pixel count on a raster stream. All outputs are registered (1-cycle latency).
module conv_postproc #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BORDER = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iDATA,
    input  logic        iDVAL,
    input  logic        iCLR,
    input  logic        iBIN_EN,
    input  logic [11:0] iTHRESH,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic        oSOF,
    output logic        oEOF,
    output logic [18:0] oEDGE_CNT,
    output logic        oCNT_VLD
);

    localparam logic [9:0] LAST_X   = 10'(IMG_W - 1);
    localparam logic [8:0] LAST_Y   = 9'(IMG_H - 1);
    localparam logic [9:0] BORDER_X = 10'(BORDER);
    localparam logic [8:0] BORDER_Y = 9'(BORDER);

    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [18:0] r_acc;

    logic        w_first;
    logic        w_last_x;
    logic        w_last;
    logic        w_masked;
    logic        w_hit;
    logic        w_edge;
    logic [11:0] w_pix;
    logic [18:0] w_acc_next;

    always_comb begin
        w_first    = (r_x == '0) && (r_y == '0);
        w_last_x   = (r_x == LAST_X);
        w_last     = w_last_x && (r_y == LAST_Y);
        w_masked   = (r_x < BORDER_X) || (r_y < BORDER_Y);
        w_hit      = (iDATA >= iTHRESH);
        w_edge     = !w_masked && w_hit;
        w_acc_next = r_acc + 19'(w_edge);
        w_pix      = '0;
        if (!w_masked) begin
            w_pix = iBIN_EN ? {12{w_hit}} : iDATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            oDATA     <= '0;
            oDVAL     <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oSOF      <= 1'b0;
            oEOF      <= 1'b0;
            oEDGE_CNT <= '0;
            oCNT_VLD  <= 1'b0;
        end else if (iCLR) begin
            // Restart drops any concurrent pixel; data/position outputs keep their last value.
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            oDVAL    <= 1'b0;
            oSOF     <= 1'b0;
            oEOF     <= 1'b0;
            oCNT_VLD <= 1'b0;
        end else begin
            oDVAL    <= iDVAL;
            oSOF     <= iDVAL && w_first;
            oEOF     <= iDVAL && w_last;
            oCNT_VLD <= iDVAL && w_last;
            if (iDVAL) begin
                oDATA <= w_pix;
                oX    <= r_x;
                oY    <= r_y;
                if (w_last) begin
                    r_x       <= '0;
                    r_y       <= '0;
                    r_acc     <= '0;
                    oEDGE_CNT <= w_acc_next;
                end else begin
                    r_acc <= w_acc_next;
                    if (w_last_x) begin
                        r_x <= '0;
                        r_y <= r_y + 9'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_postproc.sv
// Randomized bench for conv_postproc on a reduced image size, checked against a
// linear-pixel-index reference model of the frame.
module tb_conv_postproc;

    localparam int W    = 20;
    localparam int H    = 6;
    localparam int B    = 2;
    localparam int NPIX = W * H;
    localparam int INTERIOR = (W - B) * (H - B);

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [11:0] iDATA;
    logic        iDVAL;
    logic        iCLR;
    logic        iBIN_EN;
    logic [11:0] iTHRESH;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [9:0]  oX;
    logic [8:0]  oY;
    logic        oSOF;
    logic        oEOF;
    logic [18:0] oEDGE_CNT;
    logic        oCNT_VLD;

    conv_postproc #(
        .IMG_W (W),
        .IMG_H (H),
        .BORDER(B)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iDATA    (iDATA),
        .iDVAL    (iDVAL),
        .iCLR     (iCLR),
        .iBIN_EN  (iBIN_EN),
        .iTHRESH  (iTHRESH),
        .oDATA    (oDATA),
        .oDVAL    (oDVAL),
        .oX       (oX),
        .oY       (oY),
        .oSOF     (oSOF),
        .oEOF     (oEOF),
        .oEDGE_CNT(oEDGE_CNT),
        .oCNT_VLD (oCNT_VLD)
    );

    always #5 iCLK = ~iCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_pulses = 0;

    // reference model state: linear pixel index within the frame
    int m_pos, m_acc, m_cnt, m_data, m_x, m_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_acc = 0; m_cnt = 0; m_data = 0; m_x = 0; m_y = 0;
    endtask

    task automatic check_outputs(input logic e_dv, input logic e_sof, input logic e_eof, input logic e_cv);
        check("oDVAL", oDVAL, e_dv);
        check("oSOF", oSOF, e_sof);
        check("oEOF", oEOF, e_eof);
        check("oCNT_VLD", oCNT_VLD, e_cv);
        check("oDATA", oDATA, m_data);
        check("oX", oX, m_x);
        check("oY", oY, m_y);
        check("oEDGE_CNT", oEDGE_CNT, m_cnt);
    endtask

    task automatic cycle(input logic dv, input int d, input logic clr, input logic bin, input int th);
        int x, y;
        logic is_edge, e_dv, e_sof, e_eof, e_cv;
        iDVAL = dv; iDATA = 12'(d); iCLR = clr; iBIN_EN = bin; iTHRESH = 12'(th);
        @(posedge iCLK);
        #1;
        e_dv = 0; e_sof = 0; e_eof = 0; e_cv = 0;
        if (clr) begin
            m_pos = 0; m_acc = 0;
        end else if (dv) begin
            x = m_pos % W;
            y = m_pos / W;
            is_edge = (x >= B) && (y >= B) && (d >= th);
            if (x < B || y < B) m_data = 0;
            else if (bin)       m_data = (d >= th) ? 4095 : 0;
            else                m_data = d;
            m_x = x; m_y = y;
            e_dv = 1;
            e_sof = (m_pos == 0);
            e_eof = (m_pos == NPIX - 1);
            if (e_eof) begin
                m_cnt = m_acc + int'(is_edge);
                m_acc = 0;
                e_cv = 1;
            end else begin
                m_acc = m_acc + int'(is_edge);
            end
            m_pos = (m_pos + 1) % NPIX;
        end
        if (oCNT_VLD) cnt_pulses++;
        check_outputs(e_dv, e_sof, e_eof, e_cv);
    endtask

    task automatic run_frame(input int d, input logic bin, input int th);
        for (int i = 0; i < NPIX; i++) cycle(1'b1, d, 1'b0, bin, th);
    endtask

    initial begin
        iRST = 1'b0; iDATA = '0; iDVAL = 1'b0; iCLR = 1'b0; iBIN_EN = 1'b0; iTHRESH = '0;
        model_reset();
        #12;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge iCLK);
        iRST = 1'b1;

        // constant frame, no binarization
        cnt_pulses = 0;
        run_frame(1000, 1'b0, 500);
        check("t1_cnt", oEDGE_CNT, INTERIOR);
        check("t1_pulses", cnt_pulses, 1);

        // binarized, threshold just above and at the pixel value
        run_frame(1000, 1'b1, 1001);
        check("t2_cnt_zero", oEDGE_CNT, 0);
        run_frame(1000, 1'b1, 1000);
        check("t2_cnt_full", oEDGE_CNT, INTERIOR);
        check("t2_last_data", oDATA, 4095);

        // alternating valid, crossing a line wrap
        for (int i = 0; i < 2 * (W + 4); i++)
            cycle(i % 2 == 0, int'($urandom_range(4095)), 1'b0, 1'b0, 500);

        // clear with a concurrent pixel at (5,3)
        cycle(1'b0, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3 * W + 5; i++)
            cycle(1'b1, int'($urandom_range(4095)), 1'b0, 1'b0, 1500);
        check("clr_pre_x", oX, 4);
        cycle(1'b1, 1000, 1'b1, 1'b0, 500);
        check("clr_dval", oDVAL, 0);
        check("clr_cnt_kept", oEDGE_CNT, INTERIOR);
        cycle(1'b1, 1000, 1'b0, 1'b0, 500);
        check("clr_sof", oSOF, 1);
        check("clr_x0", oX, 0);

        // asynchronous reset mid-frame
        for (int i = 0; i < 30; i++)
            cycle(1'b1, int'($urandom_range(4095)), 1'b0, 1'b0, 500);
        #2 iRST = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        #1 iRST = 1'b1;
        cycle(1'b1, 2000, 1'b0, 1'b0, 500);
        check("rst_sof", oSOF, 1);
        check("rst_y0", oY, 0);

        // back-to-back frames with differing content
        cycle(1'b0, 0, 1'b1, 1'b0, 0);
        run_frame(4095, 1'b0, 100);
        check("bb_f1_cnt", oEDGE_CNT, INTERIOR);
        for (int i = 0; i < NPIX; i++)
            cycle(1'b1, int'($urandom_range(4095)), 1'b0, 1'b0, 2048);
        check("bb_f2_cnt", oEDGE_CNT, m_cnt);

        // random stream: gaps, per-pixel mode/threshold changes, rare restarts
        for (int i = 0; i < 4 * NPIX; i++)
            cycle($urandom_range(3) != 0, int'($urandom_range(4095)),
                  $urandom_range(199) == 0, 1'(($urandom_range(1))),
                  int'($urandom_range(4095)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
